// File: rtl/demosaicing_frame_ctrl_pkg.sv
// Shared types for the demosaicing frame sequencer. The Bayer pattern enum is
// the same encoding the demosaicing CSR block exposes in its pattern field.
package demosaicing_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      RGGB = 2'd0,
      GRBG = 2'd1,
      GBRG = 2'd2,
      BGGR = 2'd3
   } bayer_pattern_t;

   typedef enum logic [1:0] {
      PHASE_R  = 2'd0,
      PHASE_GR = 2'd1,
      PHASE_GB = 2'd2,
      PHASE_B  = 2'd3
   } bayer_phase_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } frame_state_t;

   // Colour under the current pixel: the pattern names the top-left 2x2 cell,
   // and odd rows/columns flip the corresponding bit of that encoding.
   function automatic bayer_phase_t bayer_phase_f(input bayer_pattern_t pat,
                                                  input logic row_odd,
                                                  input logic col_odd);
      logic [1:0] pat_bits;
      pat_bits = pat;
      return bayer_phase_t'(pat_bits ^ {row_odd, col_odd});
   endfunction

endpackage

// File: rtl/demosaicing_frame_ctrl.sv
// Frame sequencer for the bilinear demosaicing datapath: snoops the input
// stream handshake, shadows CSR settings per frame, and tracks geometry/errors.
module demosaicing_frame_ctrl
   import demosaicing_frame_ctrl_pkg::*;
#(
   parameter int COL_W = 12,
   parameter int ROW_W = 12
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             tvalid_i,
   input  logic             tready_i,
   input  logic             tuser_i,
   input  logic             tlast_i,
   input  logic             en_i,
   input  logic [1:0]       pattern_i,
   input  logic             err_clr_i,
   output logic             en_o,
   output logic [1:0]       pattern_o,
   output logic [1:0]       phase_o,
   output logic             phase_vld_o,
   output logic             frame_done_o,
   output logic [ROW_W-1:0] frame_rows_o,
   output logic [COL_W-1:0] line_width_o,
   output logic             err_width_o,
   output logic             err_sof_o,
   output logic             err_nosof_o
);

   frame_state_t   state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] width_cur_q, width_cur_d;
   logic             width_vld_q, width_vld_d;
   logic             en_q, en_d;
   bayer_pattern_t   pattern_q, pattern_d;
   logic             frame_done_q, frame_done_d;
   logic [ROW_W-1:0] frame_rows_q, frame_rows_d;
   logic [COL_W-1:0] line_width_q, line_width_d;
   logic             err_width_q, err_width_d;
   logic             err_sof_q, err_sof_d;
   logic             err_nosof_q, err_nosof_d;

   logic             beat;
   logic             sof;
   logic [COL_W-1:0] col_inc;
   logic             err_width_set;
   logic             err_sof_set;
   logic             err_nosof_set;
   bayer_pattern_t   eff_pattern;
   bayer_phase_t     phase;

   assign beat    = tvalid_i & tready_i;
   assign sof     = beat & tuser_i;
   assign col_inc = col_q + COL_W'(1);

   // The SOF beat already belongs to the new frame, so it uses the incoming
   // pattern and sits at row 0 / column 0 regardless of the old counters.
   assign eff_pattern = sof ? bayer_pattern_t'(pattern_i) : pattern_q;
   assign phase       = bayer_phase_f(eff_pattern,
                                      sof ? 1'b0 : row_q[0],
                                      sof ? 1'b0 : col_q[0]);
   assign phase_o     = phase;
   assign phase_vld_o = tvalid_i & ((state_q == ST_ACTIVE) | tuser_i);

   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      width_cur_d   = width_cur_q;
      width_vld_d   = width_vld_q;
      en_d          = en_q;
      pattern_d     = pattern_q;
      frame_done_d  = 1'b0;
      frame_rows_d  = frame_rows_q;
      line_width_d  = line_width_q;
      err_width_set = 1'b0;
      err_sof_set   = 1'b0;
      err_nosof_set = 1'b0;

      if (sof) begin
         state_d   = ST_ACTIVE;
         en_d      = en_i;
         pattern_d = bayer_pattern_t'(pattern_i);
         if (state_q == ST_ACTIVE) begin
            frame_done_d = 1'b1;
            frame_rows_d = row_q;
            line_width_d = width_cur_q;
            if (col_q != '0) begin
               err_sof_set = 1'b1;
            end
         end
         // A tlast on the SOF beat is a complete one-pixel first line.
         if (tlast_i) begin
            col_d       = '0;
            row_d       = ROW_W'(1);
            width_cur_d = COL_W'(1);
            width_vld_d = 1'b1;
         end else begin
            col_d       = COL_W'(1);
            row_d       = '0;
            width_cur_d = '0;
            width_vld_d = 1'b0;
         end
      end else if (beat) begin
         if (state_q == ST_IDLE) begin
            err_nosof_set = 1'b1;
         end else if (tlast_i) begin
            col_d = '0;
            if (row_q != '1) begin
               row_d = row_q + ROW_W'(1);
            end
            if (!width_vld_q) begin
               width_cur_d = col_inc;
               width_vld_d = 1'b1;
            end else if (col_inc != width_cur_q) begin
               err_width_set = 1'b1;
            end
         end else if (col_q == '1) begin
            err_width_set = 1'b1;
         end else begin
            col_d = col_inc;
         end
      end

      // A new error in the same cycle as a clear must survive.
      err_width_d = err_width_set | (err_width_q & ~err_clr_i);
      err_sof_d   = err_sof_set   | (err_sof_q   & ~err_clr_i);
      err_nosof_d = err_nosof_set | (err_nosof_q & ~err_clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         width_cur_q  <= '0;
         width_vld_q  <= 1'b0;
         en_q         <= 1'b0;
         pattern_q    <= RGGB;
         frame_done_q <= 1'b0;
         frame_rows_q <= '0;
         line_width_q <= '0;
         err_width_q  <= 1'b0;
         err_sof_q    <= 1'b0;
         err_nosof_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         width_cur_q  <= width_cur_d;
         width_vld_q  <= width_vld_d;
         en_q         <= en_d;
         pattern_q    <= pattern_d;
         frame_done_q <= frame_done_d;
         frame_rows_q <= frame_rows_d;
         line_width_q <= line_width_d;
         err_width_q  <= err_width_d;
         err_sof_q    <= err_sof_d;
         err_nosof_q  <= err_nosof_d;
      end
   end

   assign en_o         = en_q;
   assign pattern_o    = pattern_q;
   assign frame_done_o = frame_done_q;
   assign frame_rows_o = frame_rows_q;
   assign line_width_o = line_width_q;
   assign err_width_o  = err_width_q;
   assign err_sof_o    = err_sof_q;
   assign err_nosof_o  = err_nosof_q;

endmodule

// File: tb/tb_demosaicing_frame_ctrl.sv
// Self-checking bench for demosaicing_frame_ctrl: per-beat phase scoreboard
// plus per-scenario checks of frame stats, shadow registers and sticky errors.
module tb_demosaicing_frame_ctrl;

   localparam int COL_W = 12;
   localparam int ROW_W = 12;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tvalid, tready, tuser, tlast;
   logic             en;
   logic [1:0]       pattern;
   logic             err_clr;
   logic             en_o;
   logic [1:0]       pattern_o;
   logic [1:0]       phase_o;
   logic             phase_vld_o;
   logic             frame_done_o;
   logic [ROW_W-1:0] frame_rows_o;
   logic [COL_W-1:0] line_width_o;
   logic             err_width_o, err_sof_o, err_nosof_o;

   int checks   = 0;
   int failures = 0;
   int beat_no  = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   demosaicing_frame_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .tvalid_i     (tvalid),
      .tready_i     (tready),
      .tuser_i      (tuser),
      .tlast_i      (tlast),
      .en_i         (en),
      .pattern_i    (pattern),
      .err_clr_i    (err_clr),
      .en_o         (en_o),
      .pattern_o    (pattern_o),
      .phase_o      (phase_o),
      .phase_vld_o  (phase_vld_o),
      .frame_done_o (frame_done_o),
      .frame_rows_o (frame_rows_o),
      .line_width_o (line_width_o),
      .err_width_o  (err_width_o),
      .err_sof_o    (err_sof_o),
      .err_nosof_o  (err_nosof_o)
   );

   // One stream cycle: expected phase is queued when driven, checked at negedge.
   task automatic drive(input logic v, input logic r, input logic u, input logic l,
                        input logic exp_vld, input logic [1:0] exp_ph);
      logic [2:0] e;
      tvalid = v; tready = r; tuser = u; tlast = l;
      exp_q.push_back({exp_vld, exp_ph});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (phase_vld_o !== e[2]) begin
         failures++;
         $display("FAIL phase_vld beat %0d: got %0b want %0b", beat_no, phase_vld_o, e[2]);
      end
      if (e[2]) begin
         checks++;
         if (phase_o !== e[1:0]) begin
            failures++;
            $display("FAIL phase beat %0d: got %0d want %0d", beat_no, phase_o, e[1:0]);
         end
      end
      $display("beat %0d v=%0b r=%0b u=%0b l=%0b phase=%0d vld=%0b", beat_no, v, r, u, l,
               phase_o, phase_vld_o);
      @(posedge clk);
      #1;
      beat_no++;
   endtask

   task automatic send_line(input int n, input bit sof, input logic [1:0] pat, input int row,
                            input bit exp_done, input int exp_rows, input int exp_width);
      for (int c = 0; c < n; c++) begin
         logic [1:0] ph;
         logic       done_exp;
         ph = pat ^ {row[0], c[0]};
         drive(1'b1, 1'b1, sof && c == 0, c == n - 1, 1'b1, ph);
         done_exp = sof && c == 0 && exp_done;
         checks++;
         if (frame_done_o !== done_exp) begin
            failures++;
            $display("FAIL frame_done row %0d col %0d: got %0b want %0b", row, c, frame_done_o, done_exp);
         end
         if (done_exp) begin
            checks += 2;
            if (frame_rows_o !== ROW_W'(exp_rows)) begin
               failures++;
               $display("FAIL frame_rows: got %0d want %0d", frame_rows_o, exp_rows);
            end
            if (line_width_o !== COL_W'(exp_width)) begin
               failures++;
               $display("FAIL line_width: got %0d want %0d", line_width_o, exp_width);
            end
         end
      end
      tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++;
      if ({en_o, pattern_o, frame_done_o, frame_rows_o, line_width_o,
           err_width_o, err_sof_o, err_nosof_o} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got en=%0b pat=%0d done=%0b rows=%0d width=%0d errs=%0b%0b%0b want all 0",
                  en_o, pattern_o, frame_done_o, frame_rows_o, line_width_o,
                  err_width_o, err_sof_o, err_nosof_o);
      end
      $display("reset done");
   endtask

   task automatic test_basic_frame();
      pattern = 2'd0; en = 1'b1;
      for (int r = 0; r < 4; r++) send_line(4, r == 0, 2'd0, r, 1'b0, 0, 0);
      checks++;
      if (en_o !== 1'b1) begin
         failures++;
         $display("FAIL en_shadow: got %0b want 1", en_o);
      end
   endtask

   task automatic test_pattern_shadow();
      send_line(4, 1'b1, 2'd0, 0, 1'b1, 4, 4);
      send_line(4, 1'b0, 2'd0, 1, 1'b0, 0, 0);
      pattern = 2'd3;
      send_line(4, 1'b0, 2'd0, 2, 1'b0, 0, 0);
      checks++;
      if (pattern_o !== 2'd0) begin
         failures++;
         $display("FAIL pattern_hold: got %0d want 0", pattern_o);
      end
      send_line(4, 1'b0, 2'd0, 3, 1'b0, 0, 0);
      // SOF beat that is also a one-pixel line
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
      tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
      checks += 4;
      if (pattern_o !== 2'd3) begin
         failures++;
         $display("FAIL pattern_update: got %0d want 3", pattern_o);
      end
      if (frame_done_o !== 1'b1) begin
         failures++;
         $display("FAIL frame_done_sof_eol: got %0b want 1", frame_done_o);
      end
      if (frame_rows_o !== ROW_W'(4) || line_width_o !== COL_W'(4)) begin
         failures++;
         $display("FAIL frame_stats_4x4: got rows=%0d width=%0d want 4/4", frame_rows_o, line_width_o);
      end
      @(posedge clk);
      #1;
      if (frame_done_o !== 1'b0) begin
         failures++;
         $display("FAIL frame_done_pulse: got %0b want 0", frame_done_o);
      end
   endtask

   task automatic test_width_err();
      send_line(8, 1'b1, 2'd3, 0, 1'b1, 1, 1);
      send_line(8, 1'b0, 2'd3, 1, 1'b0, 0, 0);
      checks++;
      if (err_width_o !== 1'b0) begin
         failures++;
         $display("FAIL err_width_equal: got %0b want 0", err_width_o);
      end
      send_line(7, 1'b0, 2'd3, 2, 1'b0, 0, 0);
      checks++;
      if (err_width_o !== 1'b1) begin
         failures++;
         $display("FAIL err_width_set: got %0b want 1", err_width_o);
      end
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      checks++;
      if (err_width_o !== 1'b0) begin
         failures++;
         $display("FAIL err_width_clear: got %0b want 0", err_width_o);
      end
      err_clr = 1'b1;
      send_line(5, 1'b0, 2'd3, 3, 1'b0, 0, 0);
      err_clr = 1'b0;
      checks++;
      if (err_width_o !== 1'b1) begin
         failures++;
         $display("FAIL err_width_set_wins: got %0b want 1", err_width_o);
      end
   endtask

   task automatic test_sof_err();
      for (int c = 0; c < 3; c++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3 ^ {1'b0, c[0]});
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
      checks += 3;
      if (err_sof_o !== 1'b1) begin
         failures++;
         $display("FAIL err_sof: got %0b want 1", err_sof_o);
      end
      if (frame_done_o !== 1'b1) begin
         failures++;
         $display("FAIL frame_done_midline: got %0b want 1", frame_done_o);
      end
      if (frame_rows_o !== ROW_W'(4) || line_width_o !== COL_W'(8)) begin
         failures++;
         $display("FAIL frame_stats_sof: got rows=%0d width=%0d want 4/8", frame_rows_o, line_width_o);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
      tvalid = 1'b0;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      checks++;
      if ({err_width_o, err_sof_o, err_nosof_o} !== 3'b000) begin
         failures++;
         $display("FAIL err_clear_all: got %0b%0b%0b want 000", err_width_o, err_sof_o, err_nosof_o);
      end
   endtask

   task automatic test_no_sof();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
         checks++;
         if (frame_done_o !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_idle: got %0b want 0", frame_done_o);
         end
      end
      tvalid = 1'b0;
      checks++;
      if (err_nosof_o !== 1'b1) begin
         failures++;
         $display("FAIL err_nosof: got %0b want 1", err_nosof_o);
      end
   endtask

   task automatic test_reset_mid_frame();
      int col;
      pattern = 2'd1; en = 1'b1;
      send_line(2, 1'b1, 2'd1, 0, 1'b0, 0, 0);
      send_line(2, 1'b0, 2'd1, 1, 1'b0, 0, 0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
      checks++;
      if (frame_done_o !== 1'b1 || frame_rows_o !== ROW_W'(2) || line_width_o !== COL_W'(2)) begin
         failures++;
         $display("FAIL frame_stats_2x2: got done=%0b rows=%0d width=%0d want 1/2/2",
                  frame_done_o, frame_rows_o, line_width_o);
      end
      col = 1;
      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 3))
            0:       drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1 ^ {1'b0, col[0]});
            1:       drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
            2:       drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
            default: begin
               drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1 ^ {1'b0, col[0]});
               col++;
            end
         endcase
      end
      // one stalled beat to show col reflects only accepted beats
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1 ^ {1'b0, col[0]});
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tvalid = 1'b0; tready = 1'b0;
      checks++;
      if ({en_o, pattern_o, frame_done_o, frame_rows_o, line_width_o,
           err_width_o, err_sof_o, err_nosof_o} !== '0) begin
         failures++;
         $display("FAIL reset_mid_frame: got en=%0b pat=%0d done=%0b rows=%0d width=%0d errs=%0b%0b%0b want all 0",
                  en_o, pattern_o, frame_done_o, frame_rows_o, line_width_o,
                  err_width_o, err_sof_o, err_nosof_o);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      tvalid = 1'b0;
      checks++;
      if (err_nosof_o !== 1'b0) begin
         failures++;
         $display("FAIL stall_in_idle: got err_nosof=%0b want 0", err_nosof_o);
      end
   endtask

   initial begin
      rst_n = 1'b0; tvalid = 1'b0; tready = 1'b0; tuser = 1'b0; tlast = 1'b0;
      en = 1'b0; pattern = 2'd0; err_clr = 1'b0;
      test_reset();
      test_basic_frame();
      test_pattern_shadow();
      test_width_err();
      test_sof_err();
      test_no_sof();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demosaicing_frame_ctrl.md
Name: demosaicing_frame_ctrl

Overview:
Frame-level sequencer for the 3x3 bilinear demosaicing datapath. It snoops the AXI4-Stream handshake at the demosaicing input and shadows the CSR enable/pattern so they change only on frame boundaries. It generates the per-pixel Bayer colour phase and reports per-frame geometry and sync errors back to the CSR block.

Parameters:
COL_W, 12, width of column counter and line-width status (max line 2^COL_W-1 px)
ROW_W, 12, width of row counter and frame-rows status

Ports:
clk_i  in  1  pixel clock
rst_n_i  in  1  synchronous active-low reset
tvalid_i  in  1  snooped input-stream valid
tready_i  in  1  snooped input-stream ready
tuser_i  in  1  start-of-frame marker on first pixel
tlast_i  in  1  end-of-line marker on last pixel of line
en_i  in  1  CSR enable (demosaicing_ctrl en)
pattern_i  in  2  CSR Bayer pattern: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
err_clr_i  in  1  pulse, clears sticky errors
en_o  out  1  frame-stable enable to datapath
pattern_o  out  2  frame-stable pattern
phase_o  out  2  colour of current beat: 0 R, 1 Gr, 2 Gb, 3 B
phase_vld_o  out  1  phase_o meaningful for current beat
frame_done_o  out  1  one-cycle pulse, previous frame stats updated
frame_rows_o  out  ROW_W  line count of last completed frame
line_width_o  out  COL_W  pixels per line of last completed frame
err_width_o  out  1  sticky: line length mismatch or column overflow
err_sof_o  out  1  sticky: SOF arrived mid-line
err_nosof_o  out  1  sticky: beat accepted while IDLE without SOF

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is synchronous and active-low.
- Beat: tvalid_i && tready_i. SOF beat: beat && tuser_i.
- Reset (also mid-frame): state IDLE. All counters and status are 0. en_o=0, pattern_o=0, all errors 0, frame_done_o=0.
- States:
  - IDLE -> ACTIVE on SOF beat.
  - ACTIVE stays until reset. An SOF beat in ACTIVE closes the current frame and opens the next.
- Shadow registers:
  - On every SOF beat, en_o <= en_i and pattern_o <= pattern_i.
  - Otherwise they hold. CSR writes mid-frame take effect only at the next SOF.
- Phase:
  - eff_pattern = SOF beat ? pattern_i : pattern_o.
  - row_odd and col_odd are forced 0 on an SOF beat.
  - phase_o = eff_pattern XOR {row_odd, col_odd}. This is combinational, zero latency.
  - phase_vld_o = tvalid_i && (state==ACTIVE || tuser_i).
- Counters (ACTIVE):
  - col increments per beat. On a tlast beat, col <= 0 and row increments.
  - row_odd = row[0], col_odd = col[0].
  - col saturates at all-ones and sets err_width_o.
  - row saturates at all-ones (no error).
- Width check:
  - The first tlast of a frame latches width_cur = col+1.
  - Each later tlast compares col+1 with width_cur. A mismatch sets err_width_o.
- SOF handling:
  - SOF beat with tlast_i on the same beat: a 1-pixel line. SOF processing first, then EOL (col=0, row=1, width_cur=1).
  - SOF beat in ACTIVE with col!=0: sets err_sof_o. The frame still closes and counters restart.
- Frame close (SOF beat in ACTIVE):
  - Next cycle frame_done_o=1, frame_rows_o <= row, line_width_o <= width_cur.
  - Then row <= 0, col <= 1 (or 0 if tlast_i).
- IDLE non-SOF beat: sets err_nosof_o. No counting; phase_vld_o=0.
- Sticky errors clear on err_clr_i. If set and clear occur in the same cycle, set wins.
- Stalls (tvalid without tready, or tready without tvalid) change nothing.

Decomposition:
- Package demosaicing_frame_ctrl_pkg holds:
  - enum bayer_pattern_t (RGGB..BGGR, 2 bit)
  - enum bayer_phase_t (R, GR, GB, B)
  - enum frame_state_t (IDLE, ACTIVE)
- Share the pattern enum with the demosaicing CSR package.
- No sub-module. Counters, shadow registers and phase XOR are inline; the expected size is about 200 lines.

Test Plan:
1. Reset, pattern_i=0, en_i=1, 4x4 frame, then SOF of the next frame -> phases row0 R,Gr,R,Gr; row1 Gb,B,Gb,B. frame_done_o pulses one cycle after the second SOF, with frame_rows_o=4 and line_width_o=4.
2. pattern_i 0->3 written mid-frame -> phase_o unchanged until next SOF. The SOF beat itself shows B (3), and pattern_o=3 from the following cycle.
3. Line lengths 8,8,7 in one frame -> err_width_o=1 after the third tlast. err_clr_i pulse -> 0. err_clr_i coincident with a new mismatch -> stays 1.
4. SOF at col=3 -> err_sof_o=1, frame_done_o pulse, counters restart, and the next beat has phase for col 1.
5. Beats before any SOF after reset -> err_nosof_o=1, phase_vld_o=0, frame_done_o never asserted.
6. rst_n_i low for one cycle mid-frame, with random tvalid/tready stalls -> all outputs 0, IDLE. Stalled cycles never advance col.
